// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and a saturating mispredict counter
module branch_predictor #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int MCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_is_jump,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispred,
  input  logic              inv_all,
  output logic [MCNT_W-1:0] mispred_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [XLEN-1:0] target [ENTRIES];
  logic [1:0] cnt [ENTRIES];
  logic [IDX_W-1:0] ri, wi;
  logic [TAG_W-1:0] rt, wt;
  logic w_hit, w_en;
  logic [1:0] w_cnt;
  logic unused;
  assign unused = ^{pc_if[1:0], upd_pc[1:0]};
  always_comb begin
    ri = pc_if[IDX_W+1:2];
    rt = pc_if[XLEN-1:IDX_W+2];
    wi = upd_pc[IDX_W+1:2];
    wt = upd_pc[XLEN-1:IDX_W+2];
    pred_taken = valid[ri] && tag[ri] == rt && cnt[ri][1];
    pred_target = pred_taken ? target[ri] : pc_if + XLEN'(4);
    w_hit = valid[wi] && tag[wi] == wt;
    w_en = upd_valid && (w_hit || upd_taken);
    // a miss only writes when taken, so allocation starts at weak/strong taken
    w_cnt = upd_is_jump ? 2'b11 :
            !w_hit ? 2'b10 :
            upd_taken ? (cnt[wi] == 2'b11 ? 2'b11 : cnt[wi] + 2'd1) :
            (cnt[wi] == 2'b00 ? 2'b00 : cnt[wi] - 2'd1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        target[i] <= '0;
        cnt[i] <= CNT_INIT;
      end
    end else if (inv_all) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_INIT;
    end else if (w_en) begin
      valid[wi] <= 1'b1;
      tag[wi] <= wt;
      cnt[wi] <= w_cnt;
      if (upd_taken || upd_is_jump) target[wi] <= upd_target;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) mispred_count <= '0;
    else if (upd_valid && upd_mispred && !(&mispred_count)) mispred_count <= mispred_count + MCNT_W'(1);
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus against an abstract BTB model plus literal spot checks
module tb_branch_predictor;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_if = '0, upd_pc = '0, upd_target = '0;
  logic upd_valid = 1'b0, upd_taken = 1'b0, upd_is_jump = 1'b0, upd_mispred = 1'b0, inv_all = 1'b0;
  logic pred_taken;
  logic [31:0] pred_target;
  logic [3:0] mispred_count;
  int nerr = 0, ntot = 0;
  bit m_v [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int m_c [16];
  int m_mc;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_INIT(2'b01), .MCNT_W(4)) dut (
    .clk(clk), .reset(reset), .pc_if(pc_if), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .inv_all(inv_all), .mispred_count(mispred_count)
  );

  function automatic bit m_hit(logic [31:0] pc);
    int e = int'(pc[5:2]);
    return m_v[e] && m_tag[e] == int'(pc >> 6);
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && m_c[int'(pc[5:2])] >= 2;
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? m_tgt[int'(pc[5:2])] : pc + 32'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 1'b0;
        m_tag[i] = 0;
        m_tgt[i] = '0;
        m_c[i] = 1;
      end
      m_mc = 0;
    end else begin
      int e;
      e = int'(upd_pc[5:2]);
      if (upd_valid && upd_mispred) m_mc = m_mc == 15 ? 15 : m_mc + 1;
      if (inv_all) begin
        for (int i = 0; i < 16; i++) begin
          m_v[i] = 1'b0;
          m_c[i] = 1;
        end
      end else if (upd_valid) begin
        if (m_hit(upd_pc)) begin
          if (upd_is_jump) m_c[e] = 3;
          else if (upd_taken) m_c[e] = m_c[e] == 3 ? 3 : m_c[e] + 1;
          else m_c[e] = m_c[e] == 0 ? 0 : m_c[e] - 1;
          if (upd_taken || upd_is_jump) m_tgt[e] = upd_target;
        end else if (upd_taken) begin
          m_v[e] = 1'b1;
          m_tag[e] = int'(upd_pc >> 6);
          m_tgt[e] = upd_target;
          m_c[e] = upd_is_jump ? 3 : 2;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_taken", {31'd0, pred_taken}, {31'd0, m_taken(pc_if)});
    chk("model_target", pred_target, m_target(pc_if));
    chk("model_mcnt", {28'd0, mispred_count}, m_mc);
  end

  task automatic upd(logic [31:0] pc, logic [31:0] upc, logic tk, logic jmp, logic [31:0] tgt, logic mis, logic inv);
    @(posedge clk);
    #1;
    pc_if = pc;
    upd_valid = 1'b1;
    upd_pc = upc;
    upd_taken = tk;
    upd_is_jump = jmp;
    upd_target = tgt;
    upd_mispred = mis;
    inv_all = inv;
    #1;
  endtask

  task automatic idle(logic [31:0] pc);
    @(posedge clk);
    #1;
    pc_if = pc;
    upd_valid = 1'b0;
    upd_mispred = 1'b0;
    inv_all = 1'b0;
    #1;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    pc_if = 32'h100;
    #3;
    chk("rst_taken", {31'd0, pred_taken}, 0);
    chk("rst_target", pred_target, 32'h104);
    chk("rst_mcnt", {28'd0, mispred_count}, 0);
    #8 reset = 1'b0;
    idle(32'h100);
    chk("idle_taken", {31'd0, pred_taken}, 0);
    chk("idle_target", pred_target, 32'h104);
    upd(32'h40, 32'h40, 1, 0, 32'h80, 0, 0);
    chk("alloc_pre", {31'd0, pred_taken}, 0);
    idle(32'h40);
    chk("alloc_taken", {31'd0, pred_taken}, 1);
    chk("alloc_target", pred_target, 32'h80);
    upd(32'h40, 32'h40, 0, 0, 32'h0, 1, 0);
    idle(32'h40);
    chk("nt_taken", {31'd0, pred_taken}, 0);
    chk("nt_target", pred_target, 32'h44);
    upd(32'h40, 32'h40, 1, 0, 32'h80, 0, 0);
    idle(32'h40);
    chk("retrain_taken", {31'd0, pred_taken}, 1);
    repeat (3) upd(32'h40, 32'h40, 1, 0, 32'h80, 0, 0);
    upd(32'h40, 32'h40, 0, 0, 32'h0, 0, 0);
    idle(32'h40);
    chk("hyst_taken", {31'd0, pred_taken}, 1);
    chk("hyst_target", pred_target, 32'h80);
    idle(32'h440);
    chk("alias_taken", {31'd0, pred_taken}, 0);
    chk("alias_target", pred_target, 32'h444);
    upd(32'h40, 32'h440, 0, 0, 32'h0, 0, 0);
    idle(32'h40);
    chk("alias_keep", {31'd0, pred_taken}, 1);
    upd(32'h40, 32'h440, 1, 1, 32'h200, 1, 0);
    idle(32'h440);
    chk("jump_taken", {31'd0, pred_taken}, 1);
    chk("jump_target", pred_target, 32'h200);
    idle(32'h40);
    chk("evict_taken", {31'd0, pred_taken}, 0);
    chk("evict_target", pred_target, 32'h44);
    upd(32'h80, 32'h80, 1, 0, 32'h300, 0, 0);
    chk("rw_pre_taken", {31'd0, pred_taken}, 0);
    chk("rw_pre_target", pred_target, 32'h84);
    idle(32'h80);
    chk("rw_post_taken", {31'd0, pred_taken}, 1);
    chk("rw_post_target", pred_target, 32'h300);
    idle(32'hFFFF_FFFC);
    chk("wrap_target", pred_target, 32'h0);
    upd(32'h10, 32'h10, 1, 0, 32'h500, 0, 1);
    idle(32'h10);
    chk("inv_10_taken", {31'd0, pred_taken}, 0);
    chk("inv_10_target", pred_target, 32'h14);
    chk("inv_mcnt", {28'd0, mispred_count}, 2);
    idle(32'h80);
    chk("inv_80_taken", {31'd0, pred_taken}, 0);
    repeat (20) upd(32'h20, 32'h20, 1, 0, 32'h600, 1, 0);
    idle(32'h20);
    chk("sat_mcnt", {28'd0, mispred_count}, 32'hF);
    chk("sat_taken", {31'd0, pred_taken}, 1);
    chk("sat_target", pred_target, 32'h600);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_mcnt", {28'd0, mispred_count}, 0);
    chk("areset_taken", {31'd0, pred_taken}, 0);
    chk("areset_target", pred_target, 32'h24);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(32'h20);
    chk("post_reset_taken", {31'd0, pred_taken}, 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, ntot);
    $finish;
  end
endmodule
